// File: rtl/spmc_pwm_capture.sv
// rtl/spmc_pwm_capture.sv - per-channel PWM period/high-time capture peripheral
// Optional interrupt output enabled by defining SPMC_PWM_CAPTURE_IRQ_EN.
module spmc_pwm_capture #(
    parameter int         CHANNELS = 2,
    parameter logic [9:0] BASE_ADR = 10'h0
) (
    input  logic                clk_peri,
    input  logic                reset,
    input  logic [17:0]         do_peri,
    output logic [17:0]         di_peri,
    input  logic [9:0]          addr_peri,
    input  logic                access_peri,
    input  logic                wr_peri,
    input  logic [CHANNELS-1:0] pwm_in
`ifdef SPMC_PWM_CAPTURE_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic                select;
    logic                ctrl_wr;
    logic                en_wr;
    logic [4:0]          ch_sel;
    logic                vsel;
    logic                snap_pend;
    logic [31:0]         snapshot;
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] en_nxt;
    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] overflow;
    logic [CHANNELS-1:0] valid_nxt;
    logic [CHANNELS-1:0] overflow_nxt;
    logic [31:0]         period_arr [CHANNELS];
    logic [31:0]         high_arr   [CHANNELS];
    logic                sel_valid;
    logic                sel_overflow;
    logic [31:0]         sel_value;
    logic                unused_bits;

    assign select  = access_peri & (addr_peri[9:2] == BASE_ADR[9:2]);
    assign ctrl_wr = select & wr_peri & (addr_peri[1:0] == 2'd0);
    assign en_wr   = select & wr_peri & (addr_peri[1:0] == 2'd3);
    assign en_nxt  = en_wr ? do_peri[CHANNELS-1:0] : enable;
    assign unused_bits = ^do_peri[17:7];

    // Snapshot is taken one cycle after the CTRL write, once ch_sel/vsel hold the new selection.
    always_ff @(posedge clk_peri) begin
        if (reset) begin
            enable    <= '0;
            ch_sel    <= '0;
            vsel      <= 1'b0;
            snap_pend <= 1'b0;
            snapshot  <= '0;
        end else begin
            enable    <= en_nxt;
            snap_pend <= ctrl_wr;
            if (ctrl_wr) begin
                ch_sel <= do_peri[4:0];
                vsel   <= do_peri[5];
            end
            if (snap_pend) begin
                snapshot <= sel_value;
            end
        end
    end

    // Out-of-range channel indices fall through to the zero defaults.
    always_comb begin
        sel_valid    = 1'b0;
        sel_overflow = 1'b0;
        sel_value    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == 5'(i)) begin
                sel_valid    = valid[i];
                sel_overflow = overflow[i];
                sel_value    = vsel ? high_arr[i] : period_arr[i];
            end
        end
    end

    always_comb begin
        di_peri = '0;
        if (select & ~wr_peri & ~reset) begin
            case (addr_peri[1:0])
                2'd0:    di_peri = {16'b0, sel_overflow, sel_valid};
                2'd1:    di_peri = snapshot[17:0];
                2'd2:    di_peri = {4'b0, snapshot[31:18]};
                default: di_peri = 18'(enable);
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic        sync1;
        logic        sync2;
        logic        sync3;
        logic [31:0] cnt;
        logic [31:0] period;
        logic [31:0] high;
        logic        armed;
        logic        valid_q;
        logic        overflow_q;
        logic        rise;
        logic        fall;
        logic        clr;
        logic        capture;
        logic        sat;

        assign rise    = sync2 & ~sync3;
        assign fall    = ~sync2 & sync3;
        assign clr     = ctrl_wr & do_peri[6] & (do_peri[4:0] == 5'(g));
        assign capture = enable[g] & rise & armed;
        // Overflow fires once, on the step into saturation, so a clear is not undone while cnt sits at max.
        assign sat     = enable[g] & ~rise & (cnt == CNT_MAX - 32'd1);

        assign valid_nxt[g]    = capture | (valid_q & ~clr);
        assign overflow_nxt[g] = sat | (overflow_q & ~clr);

        always_ff @(posedge clk_peri) begin
            if (reset) begin
                sync1      <= 1'b0;
                sync2      <= 1'b0;
                sync3      <= 1'b0;
                cnt        <= '0;
                period     <= '0;
                high       <= '0;
                armed      <= 1'b0;
                valid_q    <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                sync1      <= pwm_in[g];
                sync2      <= sync1;
                sync3      <= sync2;
                valid_q    <= valid_nxt[g];
                overflow_q <= overflow_nxt[g];
                if (!enable[g]) begin
                    cnt   <= '0;
                    armed <= 1'b0;
                end else if (rise) begin
                    if (armed) begin
                        period <= cnt;
                    end
                    cnt   <= 32'd1;
                    armed <= 1'b1;
                end else begin
                    if (fall && armed) begin
                        high <= cnt;
                    end
                    if (sat) begin
                        cnt   <= CNT_MAX;
                        armed <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 32'd1;
                    end
                end
            end
        end

        assign valid[g]      = valid_q;
        assign overflow[g]   = overflow_q;
        assign period_arr[g] = period;
        assign high_arr[g]   = high;
    end

`ifdef SPMC_PWM_CAPTURE_IRQ_EN
    always_ff @(posedge clk_peri) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(valid_nxt & en_nxt);
        end
    end
`else
    logic unused_nxt;
    assign unused_nxt = ^overflow_nxt;
`endif

endmodule
